// File: rtl/blink_period_meter_pkg.sv
// Shared types and constants for the blink period meter.
package blink_period_meter_pkg;

  // Meter is either waiting for an arming edge or timing a half-period.
  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } meter_state_t;

  // Number of metastability flops ahead of the level register.
  localparam int SYNC_DEPTH = 2;

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond tick generator: free-running modulo-TICKS_PER_MS counter with a
// synchronous clear so callers can restart the millisecond grid on demand.
module ms_tick_gen #(
  parameter int TICKS_PER_MS = 100000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CW = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICKS_PER_MS - 1);

  logic [CW-1:0] count_reg;

  // tick is combinational so it is visible on the same cycle the count hits LAST
  assign tick = (count_reg == LAST);

  // Prescaler: wrap at LAST, restart from zero when cleared.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count_reg <= '0;
    end else if (tick) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_reg + {{(CW-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/blink_period_meter.sv
// Blink period meter: synchronizes an asynchronous toggling line, detects both
// edges and reports the time between consecutive edges in milliseconds.
module blink_period_meter
  import blink_period_meter_pkg::*;
#(
  parameter int bits         = 16,
  parameter int TICKS_PER_MS = 100000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            sigIn,
  output logic [bits-1:0] halfPeriod,
  output logic            valid,
  output logic            stalled,
  output logic            level
);

  localparam logic [bits-1:0] MS_MAX = '1;

  logic [SYNC_DEPTH-1:0] sync_reg;
  logic                  level_reg;
  logic                  level_prev_reg;
  logic                  edge_det;
  logic                  tick;
  logic                  prescale_clear;

  meter_state_t          state_reg, state_next;
  logic [bits-1:0]       ms_count_reg, ms_count_next;
  logic [bits-1:0]       half_period_reg, half_period_next;
  logic                  valid_reg, valid_next;
  logic                  stalled_reg, stalled_next;
  logic [bits:0]         ms_sum;

  // Synchronizer chain: stage 0 samples the async input, later stages re-time it.
  generate
    for (genvar gi = 0; gi < SYNC_DEPTH; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        // First stage captures the raw asynchronous input.
        always_ff @(posedge clk) begin
          if (reset) sync_reg[gi] <= 1'b0;
          else       sync_reg[gi] <= sigIn;
        end
      end else begin : g_rest
        // Later stages give the first stage time to resolve.
        always_ff @(posedge clk) begin
          if (reset) sync_reg[gi] <= 1'b0;
          else       sync_reg[gi] <= sync_reg[gi-1];
        end
      end
    end
  endgenerate

  // Level register plus its delayed copy for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      level_reg      <= 1'b0;
      level_prev_reg <= 1'b0;
    end else begin
      level_reg      <= sync_reg[SYNC_DEPTH-1];
      level_prev_reg <= level_reg;
    end
  end

  assign edge_det       = level_reg ^ level_prev_reg;
  // Restart the ms grid at every edge so ticks land on whole ms after it.
  assign prescale_clear = edge_det || (state_reg == IDLE);

  ms_tick_gen #(
    .TICKS_PER_MS(TICKS_PER_MS)
  ) u_ms_tick_gen (
    .clk  (clk),
    .reset(reset),
    .clear(prescale_clear),
    .tick (tick)
  );

  // A tick coincident with the closing edge belongs to the measurement.
  assign ms_sum = {1'b0, ms_count_reg} + {{bits{1'b0}}, tick};

  // Next-state logic: arm on first edge, report on later edges, time out at full scale.
  always_comb begin
    state_next       = state_reg;
    ms_count_next    = ms_count_reg;
    half_period_next = half_period_reg;
    valid_next       = 1'b0;
    stalled_next     = stalled_reg;
    case (state_reg)
      IDLE: begin
        ms_count_next = '0;
        if (edge_det) begin
          state_next   = MEASURE;
          stalled_next = 1'b0;
        end
      end
      MEASURE: begin
        if (edge_det) begin
          half_period_next = ms_sum[bits] ? MS_MAX : ms_sum[bits-1:0];
          valid_next       = 1'b1;
          ms_count_next    = '0;
        end else if (tick) begin
          if (ms_count_reg == MS_MAX) begin
            stalled_next  = 1'b1;
            state_next    = IDLE;
            ms_count_next = '0;
          end else begin
            ms_count_next = ms_count_reg + {{(bits-1){1'b0}}, 1'b1};
          end
        end
      end
      default: begin
        state_next    = IDLE;
        ms_count_next = '0;
      end
    endcase
  end

  // State, counter and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= IDLE;
      ms_count_reg    <= '0;
      half_period_reg <= '0;
      valid_reg       <= 1'b0;
      stalled_reg     <= 1'b0;
    end else begin
      state_reg       <= state_next;
      ms_count_reg    <= ms_count_next;
      half_period_reg <= half_period_next;
      valid_reg       <= valid_next;
      stalled_reg     <= stalled_next;
    end
  end

  assign halfPeriod = half_period_reg;
  assign valid      = valid_reg;
  assign stalled    = stalled_reg;
  assign level      = level_reg;

endmodule
